// File: rtl/fetch_miss_ctrl_pkg.sv
// rtl/fetch_miss_ctrl_pkg.sv - shared types and constants for instruction-side miss handling
//
// Contents:
//   ICACHE_LINE_BEATS  32-bit beats per I-cache line
//   L2TLB_*            field positions inside an L2 TLB response entry
//   fm_state_t         miss-sequencer state encoding
//   line_align()       clears the byte offset within an I-cache line
package fetch_miss_ctrl_pkg;

    localparam int ICACHE_LINE_BEATS = 8;

    localparam int PAGE_OFFSET_BITS = 12;
    localparam int L2TLB_PPN_MSB    = 31;
    localparam int L2TLB_PPN_LSB    = 12;
    localparam int L2TLB_FAULT_BIT  = 0;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        TLB_REQ    = 3'd1,
        TLB_WAIT   = 3'd2,
        CACHE_REQ  = 3'd3,
        CACHE_FILL = 3'd4,
        DRAIN      = 3'd5
    } fm_state_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr, input int beats);
        return addr & ~(32'(beats * 4) - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_miss_ctrl.sv
// rtl/fetch_miss_ctrl.sv - fetch-side ITLB / I-cache miss sequencer
//
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_flush                        abandon the miss in progress (redirect)
//   i_itlb_miss, i_icache_miss     fetch miss levels, sampled in IDLE
//   i_vaddr, i_paddr               fetch VA and translated PA
//   o_stall                        front-end hold (combinational)
//   o_l2tlb_*  / i_l2tlb_*         L2 TLB request, ack, response
//   o_itlb_fill*                   ITLB write strobe with VPN/PPN
//   o_l2cache_* / i_l2cache_*      L2 line request, ack, data beats
//   o_icache_fill_*                I-cache beat writes and line-done pulse
//   o_page_fault                   ITLB page-fault pulse
//   i_log_fd                       simulation log descriptor, 0 disables logging
module fetch_miss_ctrl
    import fetch_miss_ctrl_pkg::*;
#(
    parameter int LINE_BEATS = ICACHE_LINE_BEATS
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_flush,
    input  logic                          i_itlb_miss,
    input  logic                          i_icache_miss,
    input  logic [31:0]                   i_vaddr,
    input  logic [31:0]                   i_paddr,
    output logic                          o_stall,
    output logic                          o_l2tlb_req,
    output logic [31:0]                   o_l2tlb_vaddr,
    input  logic                          i_l2tlb_ack,
    input  logic                          i_l2tlb_resp,
    input  logic [31:0]                   i_l2tlb_entry,
    output logic                          o_itlb_fill,
    output logic [19:0]                   o_itlb_fill_vpn,
    output logic [19:0]                   o_itlb_fill_ppn,
    output logic                          o_l2cache_req,
    output logic [31:0]                   o_l2cache_paddr,
    input  logic                          i_l2cache_ack,
    input  logic                          i_l2cache_resp,
    input  logic [31:0]                   i_l2cache_data,
    output logic                          o_icache_fill_we,
    output logic [$clog2(LINE_BEATS)-1:0] o_icache_fill_idx,
    output logic [31:0]                   o_icache_fill_data,
    output logic                          o_icache_fill_done,
    output logic                          o_page_fault,
    input  logic [31:0]                   i_log_fd
);

    localparam int IDX_W = $clog2(LINE_BEATS);
    localparam int OWE_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINE_BEATS - 1);
    localparam logic [OWE_W-1:0] FULL_LINE = OWE_W'(LINE_BEATS);

    fm_state_t state_q, state_d;

    logic [19:0]       vpn_q;
    logic [11:0]       offset_q;
    logic [IDX_W-1:0]  beat_q;
    logic [OWE_W-1:0]  owed_q, owed_d;     // responses still to swallow in DRAIN
    logic              drain_cache_q, drain_cache_d;
    logic              line_done_q;        // last beat written, done pulse owed next

    logic              beat_we;
    logic              itlb_fill;
    logic              fault;
    logic              done;
    logic              drain_resp;
    logic [OWE_W-1:0]  remaining;

    logic [19:0] entry_ppn;
    logic        entry_fault;
    logic        unused_entry_bits;

    assign entry_ppn         = i_l2tlb_entry[L2TLB_PPN_MSB:L2TLB_PPN_LSB];
    assign entry_fault       = i_l2tlb_entry[L2TLB_FAULT_BIT];
    assign unused_entry_bits = ^i_l2tlb_entry[L2TLB_PPN_LSB-1:L2TLB_FAULT_BIT+1];
    assign remaining         = FULL_LINE - {1'b0, beat_q};

    assign o_stall = (state_q != IDLE) | ((i_itlb_miss | i_icache_miss) & ~i_flush);

    always_comb begin
        state_d       = state_q;
        owed_d        = owed_q;
        drain_cache_d = drain_cache_q;
        beat_we       = 1'b0;
        itlb_fill     = 1'b0;
        fault         = 1'b0;
        done          = 1'b0;
        drain_resp    = drain_cache_q ? i_l2cache_resp : i_l2tlb_resp;

        case (state_q)
            IDLE: begin
                if (!i_flush) begin
                    if (i_itlb_miss)        state_d = TLB_REQ;
                    else if (i_icache_miss) state_d = CACHE_REQ;
                end
            end
            TLB_REQ: begin
                if (i_flush) begin
                    // An accepted request still owes its response.
                    if (i_l2tlb_ack) begin
                        state_d       = DRAIN;
                        owed_d        = OWE_W'(1);
                        drain_cache_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (i_l2tlb_ack) begin
                    state_d = TLB_WAIT;
                end
            end
            TLB_WAIT: begin
                if (i_l2tlb_resp) begin
                    if (i_flush) begin
                        state_d = IDLE;
                    end else if (entry_fault) begin
                        fault   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        itlb_fill = 1'b1;
                        state_d   = CACHE_REQ;
                    end
                end else if (i_flush) begin
                    state_d       = DRAIN;
                    owed_d        = OWE_W'(1);
                    drain_cache_d = 1'b0;
                end
            end
            CACHE_REQ: begin
                if (i_flush) begin
                    if (i_l2cache_ack) begin
                        state_d       = DRAIN;
                        owed_d        = FULL_LINE;
                        drain_cache_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (i_l2cache_ack) begin
                    state_d = CACHE_FILL;
                end
            end
            CACHE_FILL: begin
                if (line_done_q) begin
                    // Stall is held through the last write so fetch never
                    // restarts ahead of the final beat landing.
                    state_d = IDLE;
                    done    = ~i_flush;
                end else if (i_flush) begin
                    // A beat arriving with the flush is abandoned, not written.
                    owed_d        = remaining - OWE_W'(i_l2cache_resp);
                    drain_cache_d = 1'b1;
                    state_d       = (owed_d == '0) ? IDLE : DRAIN;
                end else if (i_l2cache_resp) begin
                    beat_we = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_resp) begin
                    owed_d = owed_q - OWE_W'(1);
                    if (owed_q == OWE_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q            <= IDLE;
            owed_q             <= '0;
            drain_cache_q      <= 1'b0;
            line_done_q        <= 1'b0;
            beat_q             <= '0;
            vpn_q              <= '0;
            offset_q           <= '0;
            o_l2tlb_req        <= 1'b0;
            o_l2tlb_vaddr      <= '0;
            o_itlb_fill        <= 1'b0;
            o_itlb_fill_vpn    <= '0;
            o_itlb_fill_ppn    <= '0;
            o_l2cache_req      <= 1'b0;
            o_l2cache_paddr    <= '0;
            o_icache_fill_we   <= 1'b0;
            o_icache_fill_idx  <= '0;
            o_icache_fill_data <= '0;
            o_icache_fill_done <= 1'b0;
            o_page_fault       <= 1'b0;
        end else begin
            state_q            <= state_d;
            owed_q             <= owed_d;
            drain_cache_q      <= drain_cache_d;
            line_done_q        <= beat_we && (beat_q == LAST_IDX);
            o_l2tlb_req        <= (state_d == TLB_REQ);
            o_l2cache_req      <= (state_d == CACHE_REQ);
            o_itlb_fill        <= itlb_fill;
            o_page_fault       <= fault;
            o_icache_fill_we   <= beat_we;
            o_icache_fill_done <= done;

            if (state_q == IDLE && state_d == TLB_REQ) begin
                vpn_q         <= i_vaddr[31:PAGE_OFFSET_BITS];
                offset_q      <= i_vaddr[PAGE_OFFSET_BITS-1:0];
                o_l2tlb_vaddr <= {i_vaddr[31:PAGE_OFFSET_BITS], 12'h000};
            end
            if (state_q == IDLE && state_d == CACHE_REQ) begin
                o_l2cache_paddr <= line_align(i_paddr, LINE_BEATS);
            end
            if (itlb_fill) begin
                o_itlb_fill_vpn <= vpn_q;
                o_itlb_fill_ppn <= entry_ppn;
                o_l2cache_paddr <= line_align({entry_ppn, offset_q}, LINE_BEATS);
            end
            if (state_q == CACHE_REQ) begin
                beat_q <= '0;
            end
            if (beat_we) begin
                o_icache_fill_idx  <= beat_q;
                o_icache_fill_data <= i_l2cache_data;
                beat_q             <= beat_q + 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (i_rst_n && i_log_fd != 32'd0 && state_d != state_q) begin
            $display("[IFM] %s -> %s vaddr=%08h paddr=%08h",
                     state_q.name(), state_d.name(), {vpn_q, offset_q}, o_l2cache_paddr);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_miss_ctrl.sv
// tb/tb_fetch_miss_ctrl.sv - self-checking bench for fetch_miss_ctrl
module tb_fetch_miss_ctrl;
    import fetch_miss_ctrl_pkg::*;

    localparam int LB         = ICACHE_LINE_BEATS;
    localparam int IW         = $clog2(LB);
    localparam int LINE_BYTES = LB * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, flush, itlb_miss, icache_miss;
    logic [31:0]   vaddr, paddr;
    logic          stall, l2tlb_req, l2tlb_ack, l2tlb_resp;
    logic [31:0]   l2tlb_vaddr, l2tlb_entry;
    logic          itlb_fill;
    logic [19:0]   fill_vpn, fill_ppn;
    logic          l2cache_req, l2cache_ack, l2cache_resp;
    logic [31:0]   l2cache_paddr, l2cache_data;
    logic          fill_we, fill_done, page_fault;
    logic [IW-1:0] fill_idx;
    logic [31:0]   fill_data, log_fd;

    fetch_miss_ctrl #(.LINE_BEATS(LB)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_itlb_miss(itlb_miss), .i_icache_miss(icache_miss),
        .i_vaddr(vaddr), .i_paddr(paddr), .o_stall(stall),
        .o_l2tlb_req(l2tlb_req), .o_l2tlb_vaddr(l2tlb_vaddr),
        .i_l2tlb_ack(l2tlb_ack), .i_l2tlb_resp(l2tlb_resp), .i_l2tlb_entry(l2tlb_entry),
        .o_itlb_fill(itlb_fill), .o_itlb_fill_vpn(fill_vpn), .o_itlb_fill_ppn(fill_ppn),
        .o_l2cache_req(l2cache_req), .o_l2cache_paddr(l2cache_paddr),
        .i_l2cache_ack(l2cache_ack), .i_l2cache_resp(l2cache_resp), .i_l2cache_data(l2cache_data),
        .o_icache_fill_we(fill_we), .o_icache_fill_idx(fill_idx),
        .o_icache_fill_data(fill_data), .o_icache_fill_done(fill_done),
        .o_page_fault(page_fault), .i_log_fd(log_fd)
    );

    int tests = 0;
    int fails = 0;

    // Event record, sampled on the falling edge.
    int          mon_done = 0, mon_fault = 0, mon_itlb = 0, mon_creq = 0, mon_stall = 0;
    int          mon_idx[$];
    logic [31:0] mon_data[$];

    always @(negedge clk) begin
        if (fill_we) begin
            mon_idx.push_back(int'(fill_idx));
            mon_data.push_back(fill_data);
        end
        if (fill_done)   mon_done++;
        if (page_fault)  mon_fault++;
        if (itlb_fill)   mon_itlb++;
        if (l2cache_req) mon_creq++;
        if (stall)       mon_stall++;
    end

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return (a / LINE_BYTES) * LINE_BYTES;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic serve_line(input logic [31:0] exp_line, input int ack_dly, input bit gaps,
                              input bit directed, output int ng);
        int i0, d0;
        logic [31:0] exp_d[$];
        ng = 0;
        i0 = mon_idx.size();
        d0 = mon_done;
        chk("creq_up", l2cache_req, 1);
        chk("creq_addr", l2cache_paddr, exp_line);
        for (int k = 0; k < ack_dly; k++) begin
            tick;
            chk("creq_hold", l2cache_req, 1);
            chk("creq_stable", l2cache_paddr, exp_line);
        end
        l2cache_ack = 1'b1;
        tick;
        l2cache_ack = 1'b0;
        chk("creq_drop", l2cache_req, 0);
        for (int b = 0; b < LB; b++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                tick;
                ng++;
            end
            l2cache_resp = 1'b1;
            l2cache_data = directed ? 32'hA0 + 32'(b) : $urandom;
            exp_d.push_back(l2cache_data);
            tick;
            l2cache_resp = 1'b0;
        end
        chk("stall_last_we", stall, 1);
        chk("done_early", fill_done, 0);
        tick;
        chk("done_pulse", fill_done, 1);
        chk("stall_release", stall, 0);
        tick;
        chk("done_single", fill_done, 0);
        chk("beat_count", mon_idx.size() - i0, LB);
        for (int b = 0; b < LB && i0 + b < mon_idx.size(); b++) begin
            chk("beat_idx", mon_idx[i0 + b], b);
            chk("beat_data", mon_data[i0 + b], exp_d[b]);
        end
        chk("done_count", mon_done - d0, 1);
    endtask

    task automatic do_icache(input logic [31:0] pa, input int dly, input bit gaps, input bit directed);
        int s0, ng;
        s0 = mon_stall;
        icache_miss = 1'b1;
        paddr = pa;
        #1 chk("stall_comb", stall, 1);
        tick;
        icache_miss = 1'b0;
        paddr = $urandom;
        chk("no_tlb_req", l2tlb_req, 0);
        serve_line(line_of(pa), dly, gaps, directed, ng);
        chk("icache_latency", mon_stall - s0, 2 + dly + LB + 1 + ng);
    endtask

    task automatic do_itlb(input logic [31:0] va, input logic [19:0] ppn, input bit flt,
                           input int dly, input bit gaps);
        int s0, f0, t0, c0, ng;
        s0 = mon_stall; f0 = mon_fault; t0 = mon_itlb; c0 = mon_creq;
        itlb_miss = 1'b1;
        vaddr = va;
        icache_miss = 1'($urandom_range(0, 1));
        paddr = $urandom;
        tick;
        itlb_miss = 1'b0;
        icache_miss = 1'b0;
        chk("treq_up", l2tlb_req, 1);
        chk("treq_addr", l2tlb_vaddr, (va >> 12) << 12);
        chk("treq_no_creq", l2cache_req, 0);
        for (int k = 0; k < dly; k++) begin
            tick;
            chk("treq_hold", l2tlb_req, 1);
            chk("treq_stable", l2tlb_vaddr, (va >> 12) << 12);
        end
        l2tlb_ack = 1'b1;
        tick;
        l2tlb_ack = 1'b0;
        chk("treq_drop", l2tlb_req, 0);
        repeat (dly) tick;
        l2tlb_resp = 1'b1;
        l2tlb_entry = {ppn, 11'($urandom), flt};
        tick;
        l2tlb_resp = 1'b0;
        if (flt) begin
            chk("fault_pulse", page_fault, 1);
            chk("fault_no_fill", itlb_fill, 0);
            chk("fault_stall", stall, 0);
            tick;
            chk("fault_single", page_fault, 0);
            repeat (3) tick;
            chk("fault_count", mon_fault - f0, 1);
            chk("fault_fill_count", mon_itlb - t0, 0);
            chk("fault_creq_count", mon_creq - c0, 0);
            chk("fault_latency", mon_stall - s0, 3 + 2 * dly);
        end else begin
            chk("itlb_fill", itlb_fill, 1);
            chk("itlb_vpn", fill_vpn, va >> 12);
            chk("itlb_ppn", fill_ppn, ppn);
            serve_line(line_of({ppn, va[11:0]}), dly, gaps, 1'b0, ng);
            chk("itlb_fill_count", mon_itlb - t0, 1);
            chk("itlb_fault_count", mon_fault - f0, 0);
            chk("itlb_latency", mon_stall - s0, 4 + LB + 1 + 3 * dly + ng);
        end
    endtask

    initial begin
        int i0, d0, t0, f0, c0, k, ng;
        logic [31:0] pa;

        rst_n = 1'b0; flush = 1'b0; itlb_miss = 1'b0; icache_miss = 1'b0;
        vaddr = '0; paddr = '0; l2tlb_ack = 1'b0; l2tlb_resp = 1'b0; l2tlb_entry = '0;
        l2cache_ack = 1'b0; l2cache_resp = 1'b0; l2cache_data = '0; log_fd = '0;
        tick;
        tick;
        chk("rst_stall", stall, 0);
        chk("rst_treq", l2tlb_req, 0);
        chk("rst_creq", l2cache_req, 0);
        chk("rst_tva", l2tlb_vaddr, 0);
        chk("rst_cpa", l2cache_paddr, 0);
        chk("rst_we", fill_we, 0);
        chk("rst_done", fill_done, 0);
        chk("rst_fill", itlb_fill, 0);
        chk("rst_fault", page_fault, 0);
        rst_n = 1'b1;
        tick;

        // Directed cases from the miss-handling plan.
        do_icache(32'h0000_1234, 2, 1'b0, 1'b1);
        do_itlb(32'h4000_5018, 20'h12345, 1'b0, 0, 1'b0);
        do_itlb($urandom, 20'($urandom), 1'b1, 0, 1'b0);

        // Randomized misses with random delays and beat gaps.
        for (int r = 0; r < 4; r++) begin
            do_icache($urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
            do_itlb($urandom, 20'($urandom), 1'($urandom_range(0, 3) == 0),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Flush in IDLE has no effect.
        icache_miss = 1'b1; flush = 1'b1; paddr = $urandom;
        #1 chk("idle_flush_stall", stall, 0);
        tick;
        icache_miss = 1'b0; flush = 1'b0;
        chk("idle_flush_creq", l2cache_req, 0);
        chk("idle_flush_treq", l2tlb_req, 0);

        // Flush mid-fill: remaining beats swallowed, then a new miss is taken.
        for (int r = 0; r < 3; r++) begin
            k = (r == 0) ? 4 : $urandom_range(0, LB - 1);
            i0 = mon_idx.size(); d0 = mon_done;
            icache_miss = 1'b1; paddr = $urandom;
            tick;
            icache_miss = 1'b0;
            l2cache_ack = 1'b1;
            tick;
            l2cache_ack = 1'b0;
            for (int b = 0; b < k; b++) begin
                l2cache_resp = 1'b1; l2cache_data = $urandom;
                tick;
                l2cache_resp = 1'b0;
            end
            flush = 1'b1;
            tick;
            flush = 1'b0;
            for (int b = k; b < LB; b++) begin
                chk("drain_stall", stall, 1);
                l2cache_resp = 1'b1; l2cache_data = $urandom;
                tick;
                l2cache_resp = 1'b0;
            end
            chk("drain_exit", stall, 0);
            chk("drain_beats", mon_idx.size() - i0, k);
            chk("drain_done", mon_done - d0, 0);
            pa = $urandom;
            icache_miss = 1'b1; paddr = pa;
            tick;
            icache_miss = 1'b0;
            serve_line(line_of(pa), 0, 1'b0, 1'b0, ng);
        end

        // Flush during CACHE_REQ / TLB_REQ with no ack.
        icache_miss = 1'b1; paddr = $urandom;
        tick;
        icache_miss = 1'b0;
        chk("creq_before_flush", l2cache_req, 1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("creq_flush_drop", l2cache_req, 0);
        chk("creq_flush_idle", stall, 0);
        itlb_miss = 1'b1; vaddr = $urandom;
        tick;
        itlb_miss = 1'b0;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("treq_flush_drop", l2tlb_req, 0);
        chk("treq_flush_idle", stall, 0);

        // Stray responses in IDLE are ignored.
        i0 = mon_idx.size(); t0 = mon_itlb; f0 = mon_fault;
        l2cache_resp = 1'b1; l2tlb_resp = 1'b1; l2tlb_entry = $urandom;
        tick;
        l2cache_resp = 1'b0; l2tlb_resp = 1'b0;
        tick;
        chk("stray_we", mon_idx.size() - i0, 0);
        chk("stray_fill", (mon_itlb - t0) + (mon_fault - f0), 0);

        // Flush coincident with cache ack: whole line swallowed.
        i0 = mon_idx.size(); d0 = mon_done;
        icache_miss = 1'b1; paddr = $urandom;
        tick;
        icache_miss = 1'b0;
        l2cache_ack = 1'b1; flush = 1'b1;
        tick;
        l2cache_ack = 1'b0; flush = 1'b0;
        chk("ackflush_creq", l2cache_req, 0);
        for (int b = 0; b < LB; b++) begin
            chk("ackflush_stall", stall, 1);
            l2cache_resp = 1'b1; l2cache_data = $urandom;
            tick;
            l2cache_resp = 1'b0;
        end
        chk("ackflush_idle", stall, 0);
        chk("ackflush_we", mon_idx.size() - i0, 0);
        chk("ackflush_done", mon_done - d0, 0);

        // Flush coincident with TLB ack, and flush in TLB_WAIT.
        for (int r = 0; r < 2; r++) begin
            t0 = mon_itlb; f0 = mon_fault; c0 = mon_creq;
            itlb_miss = 1'b1; vaddr = $urandom;
            tick;
            itlb_miss = 1'b0;
            l2tlb_ack = 1'b1; flush = (r == 0);
            tick;
            l2tlb_ack = 1'b0;
            flush = (r == 1);
            tick;
            flush = 1'b0;
            chk("tdrain_stall", stall, 1);
            l2tlb_resp = 1'b1; l2tlb_entry = {20'($urandom), 11'd0, 1'($urandom_range(0, 1))};
            tick;
            l2tlb_resp = 1'b0;
            tick;
            chk("tdrain_idle", stall, 0);
            chk("tdrain_fill", mon_itlb - t0, 0);
            chk("tdrain_fault", mon_fault - f0, 0);
            chk("tdrain_creq", mon_creq - c0, 0);
        end

        // Reset in the middle of a line fill.
        icache_miss = 1'b1; paddr = $urandom;
        tick;
        icache_miss = 1'b0;
        l2cache_ack = 1'b1;
        tick;
        l2cache_ack = 1'b0;
        for (int b = 0; b < 3; b++) begin
            l2cache_resp = 1'b1; l2cache_data = $urandom;
            tick;
        end
        rst_n = 1'b0;
        tick;
        chk("mrst_we", fill_we, 0);
        chk("mrst_done", fill_done, 0);
        chk("mrst_creq", l2cache_req, 0);
        chk("mrst_cpa", l2cache_paddr, 0);
        chk("mrst_stall", stall, 0);
        rst_n = 1'b1;
        i0 = mon_idx.size(); d0 = mon_done;
        for (int b = 0; b < LB; b++) tick;
        l2cache_resp = 1'b0;
        tick;
        tick;
        chk("post_rst_we", mon_idx.size() - i0, 0);
        chk("post_rst_done", mon_done - d0, 0);
        chk("post_rst_stall", stall, 0);

        do_icache($urandom, 1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
